// File: rtl/gpio_pkg.sv
// ============================================================================
// Module   : gpio_pkg
// Brief    : Shared register map and edge-select encoding for the GPIO port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gpio_pkg;

    localparam logic [2:0] GPIO_REG_DATA   = 3'd0;
    localparam logic [2:0] GPIO_REG_DIR    = 3'd1;
    localparam logic [2:0] GPIO_REG_IRQ_EN = 3'd2;
    localparam logic [2:0] GPIO_REG_EDGE   = 3'd3;
    localparam logic [2:0] GPIO_REG_STATUS = 3'd4;

    localparam int c_BUS_W = 32;

    typedef enum logic {
        GPIO_EDGE_RISE = 1'b0,
        GPIO_EDGE_FALL = 1'b1
    } gpio_edge_e;

    // Edges after reset release during which the input pipeline is still
    // filling; edge events are ignored until it holds real pad data.
`ifdef GPIO_DEBOUNCE_EN
    localparam int c_ARM_DEPTH = 4;
`else
    localparam int c_ARM_DEPTH = 3;
`endif

endpackage

`default_nettype wire

// File: rtl/gpio_if.sv
// ============================================================================
// Module   : gpio_if
// Brief    : Processor-side register bus of the GPIO peripheral.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gpio_if;

    logic        ce;
    logic        we;
    logic [2:0]  reg_sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output ce, we, reg_sel, wdata, input rdata, irq);
    modport slave  (input ce, we, reg_sel, wdata, output rdata, irq);

endinterface

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ============================================================================
// Module   : gpio_debounce
// Brief    : Single-bit debouncer; output follows input after DEBOUNCE_CYCLES
//            consecutive differing samples. i_load copies input directly.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    input  wire logic i_in,
    output logic      o_out
);

    localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_out <= i_in;
        end else if (i_in == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
            r_out <= ~r_out;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_out = r_out;

endmodule

`default_nettype wire

// File: rtl/gpio_port.sv
// ============================================================================
// Module   : gpio_port
// Brief    : Bidirectional GPIO port with direction control, 2-FF input sync,
//            edge interrupts (W1C status). Optional: GPIO_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  wire logic             sys_clk,
    input  wire logic             rst_n,
    gpio_if.slave                 bus,
    inout  wire       [WIDTH-1:0] port_io
);

    logic [WIDTH-1:0]       r_dout;
    logic [WIDTH-1:0]       r_dir;
    logic [WIDTH-1:0]       r_irq_en;
    logic [WIDTH-1:0]       r_edge_sel;
    logic [WIDTH-1:0]       r_status;
    logic [WIDTH-1:0]       r_sync1;
    logic [WIDTH-1:0]       r_sync2;
    logic [WIDTH-1:0]       r_in_d;
    logic [c_ARM_DEPTH-1:0] r_arm;
    logic                   r_irq;

    logic [WIDTH-1:0]       w_in_c;
    logic [WIDTH-1:0]       w_wdata;
    logic [WIDTH-1:0]       w_event;
    logic [WIDTH-1:0]       w_clr;
    logic [WIDTH-1:0]       w_data_rd;
    logic [c_BUS_W-1:0]     w_rdata;
    logic                   w_wr;
    logic                   w_armed;

    assign w_wr    = bus.ce & bus.we;
    assign w_wdata = bus.wdata[WIDTH-1:0];
    assign w_armed = r_arm[c_ARM_DEPTH-1];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_edge_sel <= '0;
        end else if (w_wr) begin
            case (bus.reg_sel)
                GPIO_REG_DATA:   r_dout     <= w_wdata;
                GPIO_REG_DIR:    r_dir      <= w_wdata;
                GPIO_REG_IRQ_EN: r_irq_en   <= w_wdata;
                GPIO_REG_EDGE:   r_edge_sel <= w_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_in_d   <= '0;
            r_arm    <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1  <= port_io;
            r_sync2  <= r_sync1;
            r_in_d   <= w_in_c;
            r_arm    <= {r_arm[c_ARM_DEPTH-2:0], 1'b1};
            // Set has priority over a same-cycle clear.
            r_status <= (r_status & ~w_clr) | w_event;
            r_irq    <= |(r_status & r_irq_en);
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        gpio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (sys_clk),
            .rst_n  (rst_n),
            .i_load (~w_armed),
            .i_in   (r_sync2[i]),
            .o_out  (w_in_c[i])
        );
    end
`else
    assign w_in_c = r_sync2;
`endif

    // in_d tracks every bit so re-enabling an input never sees a stale level.
    for (genvar i = 0; i < WIDTH; i++) begin : g_edge
        assign w_event[i] = w_armed & ~r_dir[i] &
            ((gpio_edge_e'(r_edge_sel[i]) == GPIO_EDGE_FALL) ?
                ( r_in_d[i] & ~w_in_c[i]) :
                (~r_in_d[i] &  w_in_c[i]));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign port_io[i] = r_dir[i] ? r_dout[i] : 1'bz;
    end

    assign w_clr     = (w_wr && (bus.reg_sel == GPIO_REG_STATUS)) ? w_wdata : '0;
    assign w_data_rd = (r_dir & r_dout) | (~r_dir & w_in_c);

    always_comb begin
        w_rdata = '0;
        if (bus.ce) begin
            case (bus.reg_sel)
                GPIO_REG_DATA:   w_rdata = c_BUS_W'(w_data_rd);
                GPIO_REG_DIR:    w_rdata = c_BUS_W'(r_dir);
                GPIO_REG_IRQ_EN: w_rdata = c_BUS_W'(r_irq_en);
                GPIO_REG_EDGE:   w_rdata = c_BUS_W'(r_edge_sel);
                GPIO_REG_STATUS: w_rdata = c_BUS_W'(r_status);
                default:         w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_gpio_port.sv
// ============================================================================
// Module   : tb_gpio_port
// Brief    : Self-checking bench for gpio_port with a behavioural reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_port;
    import gpio_pkg::*;

    localparam int DEB = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int XL  = DEB;
    localparam int ARM = 4;
`else
    localparam int XL  = 0;
    localparam int ARM = 3;
`endif

    logic        sys_clk;
    logic        rst_n;
    wire  [31:0] port_io;
    logic [31:0] drv_val;
    logic [31:0] drv_en;
    int          n_checks;
    int          n_fail;

    gpio_if bus ();

    gpio_port #(
        .WIDTH           (32),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .port_io (port_io)
    );

    // External world drives every pad the port is not expected to drive.
    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign port_io[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_dout, m_dir, m_irq_en, m_edge, m_status, m_inc, m_ind;
    logic        m_irq;
    logic [31:0] m_p1, m_p2;
    int          m_edges;
    int          m_run [32];
    logic [31:0] t_pad, t_ev, t_nxt, t_clr;

    assign drv_en = ~m_dir;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout <= '0; m_dir <= '0; m_irq_en <= '0; m_edge <= '0;
            m_status <= '0; m_irq <= 1'b0; m_inc <= '0; m_ind <= '0;
            m_p1 = '0; m_p2 = '0; m_edges = 0;
            for (int i = 0; i < 32; i++) m_run[i] = 0;
        end else begin
            t_pad = (m_dir & m_dout) | (~m_dir & drv_val);
            t_ev  = '0;
            if (m_edges >= ARM)
                t_ev = ~m_dir & ((m_edge & m_ind & ~m_inc) | (~m_edge & ~m_ind & m_inc));
`ifdef GPIO_DEBOUNCE_EN
            t_nxt = m_inc;
            for (int i = 0; i < 32; i++) begin
                if (m_edges < ARM) begin
                    t_nxt[i] = m_p2[i];
                    m_run[i] = 0;
                end else if (m_p2[i] != m_inc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        t_nxt[i] = ~m_inc[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`else
            t_nxt = m_p1;
`endif
            m_p2 = m_p1;
            m_p1 = t_pad;
            t_clr = (bus.ce && bus.we && bus.reg_sel == GPIO_REG_STATUS) ? bus.wdata : '0;
            m_status <= (m_status & ~t_clr) | t_ev;
            m_irq    <= |(m_status & m_irq_en);
            m_ind    <= m_inc;
            m_inc    <= t_nxt;
            if (bus.ce && bus.we) begin
                case (bus.reg_sel)
                    GPIO_REG_DATA:   m_dout   <= bus.wdata;
                    GPIO_REG_DIR:    m_dir    <= bus.wdata;
                    GPIO_REG_IRQ_EN: m_irq_en <= bus.wdata;
                    GPIO_REG_EDGE:   m_edge   <= bus.wdata;
                    default: ;
                endcase
            end
            if (m_edges < 100) m_edges = m_edges + 1;
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        case (sel)
            GPIO_REG_DATA:   return (m_dir & m_dout) | (~m_dir & m_inc);
            GPIO_REG_DIR:    return m_dir;
            GPIO_REG_IRQ_EN: return m_irq_en;
            GPIO_REG_EDGE:   return m_edge;
            GPIO_REG_STATUS: return m_status;
            default:         return 32'h0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        check("irq", 32'(bus.irq), 32'(m_irq));
        check("rdata", bus.rdata, bus.ce ? model_read(bus.reg_sel) : 32'h0);
        check("pads", port_io, (m_dir & m_dout) | (~m_dir & drv_val));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        bus.ce = 1'b1; bus.we = 1'b1; bus.reg_sel = sel; bus.wdata = d;
        tick();
        bus.ce = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string nm);
        bus.ce = 1'b1; bus.we = 1'b0; bus.reg_sel = sel;
        #1;
        check(nm, bus.rdata, exp);
        bus.ce = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.ce = 1'b0; bus.we = 1'b0; bus.reg_sel = '0; bus.wdata = '0;
        drv_val = 32'hFFFF_FFFF;

        // Reset state; pads held high so release must not look like an edge.
        repeat (3) tick();
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, "rst_read");
        check("rst_irq", 32'(bus.irq), 32'h0);
        rst_n = 1'b1;
        repeat (6 + XL) tick();
        rd(GPIO_REG_DATA,   32'hFFFF_FFFF, "rel_data");
        rd(GPIO_REG_STATUS, 32'h0,         "rel_status");
        drv_val = 32'h0;
        repeat (4 + XL) tick();

        // Output drive
        wr(GPIO_REG_DIR, 32'hFFFF_0000);
        drv_val = 32'h0000_00FF;
        wr(GPIO_REG_DATA, 32'hA5A5_1234);
        check("pads_hi", 32'(port_io[31:16]), 32'h0000_A5A5);
        check("pads_lo", 32'(port_io[15:0]),  32'h0000_00FF);
        repeat (2 + XL) tick();
        rd(GPIO_REG_DATA,   32'hA5A5_00FF, "data_mixed");
        rd(GPIO_REG_STATUS, 32'h0000_00FF, "status_rise_lo");
        wr(GPIO_REG_STATUS, 32'hFFFF_FFFF);
        rd(GPIO_REG_STATUS, 32'h0, "status_w1c_all");

        // Rising-edge interrupt on bit 2
        wr(GPIO_REG_DIR, 32'h0);
        drv_val = 32'h0;
        repeat (4 + XL) tick();
        wr(GPIO_REG_STATUS, 32'hFFFF_FFFF);
        rd(GPIO_REG_STATUS, 32'h0, "status_pre_rise");
        wr(GPIO_REG_IRQ_EN, 32'h4);
        wr(GPIO_REG_EDGE,   32'h0);
        drv_val = 32'h4;
        repeat (2 + XL) tick();
        rd(GPIO_REG_STATUS, 32'h0, "status_n1");
        tick();
        rd(GPIO_REG_STATUS, 32'h4, "status_n2");
        check("irq_n2", 32'(bus.irq), 32'h0);
        tick();
        check("irq_n3", 32'(bus.irq), 32'h1);
        wr(GPIO_REG_STATUS, 32'h4);
        check("irq_at_clr", 32'(bus.irq), 32'h1);
        tick();
        check("irq_after_clr", 32'(bus.irq), 32'h0);
        rd(GPIO_REG_STATUS, 32'h0, "status_cleared");

        // Falling edge, masked interrupt, set-beats-clear
        wr(GPIO_REG_IRQ_EN, 32'h0);
        wr(GPIO_REG_EDGE,   32'h2);
        drv_val = 32'h6;
        repeat (4 + XL) tick();
        rd(GPIO_REG_STATUS, 32'h0, "no_evt_on_rise");
        drv_val = 32'h4;
        repeat (3 + XL) tick();
        rd(GPIO_REG_STATUS, 32'h2, "status_fall");
        tick();
        check("irq_masked", 32'(bus.irq), 32'h0);
        drv_val = 32'h6;
        repeat (4 + XL) tick();
        drv_val = 32'h4;
        repeat (2 + XL) tick();
        wr(GPIO_REG_STATUS, 32'h2);
        rd(GPIO_REG_STATUS, 32'h2, "set_beats_clr");
        wr(GPIO_REG_STATUS, 32'h2);
        rd(GPIO_REG_STATUS, 32'h0, "plain_clr");

        // Reset mid-operation
        wr(GPIO_REG_DIR,  32'h0000_FF00);
        wr(GPIO_REG_DATA, 32'h0000_FF00);
        check("pads_mid", 32'(port_io[15:8]), 32'h0000_00FF);
        wr(GPIO_REG_IRQ_EN, 32'h2);
        drv_val = 32'h6;
        repeat (4 + XL) tick();
        drv_val = 32'h4;
        repeat (4 + XL) tick();
        check("irq_pre_rst", 32'(bus.irq), 32'h1);
        rd(GPIO_REG_STATUS, 32'h2, "status_pre_rst");
        rst_n = 1'b0;
        #1;
        check("pads_float", port_io, 32'h0000_0004);
        check("irq_rst", 32'(bus.irq), 32'h0);
        drv_val = 32'hFFFF_FFFF;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6 + XL) tick();
        rd(GPIO_REG_STATUS, 32'h0,         "status_post_rst");
        rd(GPIO_REG_DIR,    32'h0,         "dir_post_rst");
        rd(GPIO_REG_DATA,   32'hFFFF_FFFF, "data_post_rst");
        check("irq_post_rst", 32'(bus.irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short glitch filtered, long level accepted
        drv_val = 32'h0;
        repeat (20) tick();
        wr(GPIO_REG_STATUS, 32'hFFFF_FFFF);
        wr(GPIO_REG_EDGE,   32'h0);
        drv_val = 32'h1;
        repeat (5) tick();
        drv_val = 32'h0;
        repeat (20) tick();
        rd(GPIO_REG_DATA,   32'h0, "glitch_data");
        rd(GPIO_REG_STATUS, 32'h0, "glitch_status");
        drv_val = 32'h1;
        repeat (9) tick();
        rd(GPIO_REG_DATA, 32'h0, "deb_n8");
        tick();
        rd(GPIO_REG_DATA,   32'h1, "deb_n9");
        rd(GPIO_REG_STATUS, 32'h0, "deb_status_n9");
        tick();
        rd(GPIO_REG_STATUS, 32'h1, "deb_status_n10");
        repeat (12) tick();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
